// File: rtl/blink_count_display_if.sv
// Display-side bundle of blink_count_display.
//   count_in  binary count to show (driven by the master / producer)
//   an        anode enables, active-low, an[0] = rightmost digit
//   seg       segments active-low, seg[0]=a .. seg[6]=g
//   dp        decimal point, active-low
//   busy      BCD conversion in progress
//   overflow  last converted value does not fit in DIGITS decimal digits
// master: producer of count_in, observer of the display pins.
// slave : the display controller itself.
interface blink_count_display_if #(
    parameter int DIGITS = 4
);
    logic [31:0]       count_in;
    logic [DIGITS-1:0] an;
    logic [6:0]        seg;
    logic              dp;
    logic              busy;
    logic              overflow;

    modport master (
        output count_in,
        input  an, seg, dp, busy, overflow
    );

    modport slave (
        input  count_in,
        output an, seg, dp, busy, overflow
    );
endinterface

// File: rtl/blink_count_display.sv
// blink_count_display
//   Converts a 32-bit binary count to BCD with a sequential double-dabble
//   engine (IDLE -> CONV x32 -> COMMIT) and scans the lowest DIGITS decimal
//   digits onto a multiplexed common-anode 7-segment display.
// Ports
//   clk   system clock, all logic on posedge
//   rst   synchronous, active-low reset
//   bus   slave side of blink_count_display_if:
//         count_in (in), an/seg/dp/busy/overflow (out, display pins active-low)
module blink_count_display #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int LZ_BLANK    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    blink_count_display_if.slave  bus
);
    localparam int RW = $clog2(REFRESH_DIV);
    localparam int SW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

    state_t              state_reg, state_next;
    logic                load, shift_en, commit;

    logic [31:0]         snapshot_reg;
    logic [31:0]         shift_reg;
    logic [39:0]         bcd_reg;
    logic [39:0]         bcd_adj;
    logic [4:0]          bit_cnt_reg;
    logic [4*DIGITS-1:0] disp_reg;
    logic                overflow_reg;

    logic [RW-1:0]       refresh_cnt_reg;
    logic [SW-1:0]       scan_idx_reg;
    logic [DIGITS-1:0]   an_reg;
    logic [6:0]          seg_reg;

    logic [3:0]          digit [DIGITS];
    logic                blank [DIGITS];
    logic [3:0]          cur_digit;
    logic                cur_blank;
    logic                changed;

    assign changed = (bus.count_in != snapshot_reg);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (changed) state_next = CONV;
            CONV:    if (bit_cnt_reg == 5'd31) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        load     = 1'b0;
        shift_en = 1'b0;
        commit   = 1'b0;
        case (state_reg)
            IDLE:    load     = changed;
            CONV:    shift_en = 1'b1;
            COMMIT:  commit   = 1'b1;
            default: ;
        endcase
    end

    // Add-3 correction on every BCD nibble ahead of the shift.
    generate
        for (genvar gi = 0; gi < 10; gi++) begin : g_adj
            assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5)
                                      ? bcd_reg[4*gi +: 4] + 4'd3
                                      : bcd_reg[4*gi +: 4];
        end
    endgenerate

    // ---------------- conversion datapath ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            snapshot_reg <= '0;
            shift_reg    <= '0;
            bcd_reg      <= '0;
            bit_cnt_reg  <= '0;
            disp_reg     <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (load) begin
                snapshot_reg <= bus.count_in;
                shift_reg    <= bus.count_in;
                bcd_reg      <= '0;
                bit_cnt_reg  <= '0;
            end
            if (shift_en) begin
                {bcd_reg, shift_reg} <= {bcd_adj[38:0], shift_reg, 1'b0};
                bit_cnt_reg          <= bit_cnt_reg + 5'd1;
            end
            if (commit) begin
                disp_reg     <= bcd_reg[4*DIGITS-1:0];
                overflow_reg <= |bcd_reg[39:4*DIGITS];
            end
        end
    end

    // Digit 0 is never blanked; higher digits blank when they and every digit
    // above are zero, unless the value overflowed (then all digits are shown).
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign digit[gi] = disp_reg[4*gi +: 4];
            if (gi == 0) begin : g_first
                assign blank[gi] = 1'b0;
            end else begin : g_upper
                assign blank[gi] = (LZ_BLANK != 0) && !overflow_reg &&
                                   (disp_reg[4*DIGITS-1:4*gi] == '0);
            end
        end
    endgenerate

    assign cur_digit = digit[scan_idx_reg];
    assign cur_blank = blank[scan_idx_reg];

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b1111111;
        endcase
    endfunction

    // ---------------- scan ----------------
    // Anode and segments are both registered from the same scan index, so
    // they always change together; a commit only alters the next seg load.
    always_ff @(posedge clk) begin
        if (!rst) begin
            refresh_cnt_reg <= '0;
            scan_idx_reg    <= '0;
            an_reg          <= '1;
            seg_reg         <= 7'h7F;
        end else begin
            if (refresh_cnt_reg == RW'(REFRESH_DIV - 1)) begin
                refresh_cnt_reg <= '0;
                scan_idx_reg    <= (scan_idx_reg == SW'(DIGITS - 1))
                                 ? '0 : scan_idx_reg + SW'(1);
            end else begin
                refresh_cnt_reg <= refresh_cnt_reg + RW'(1);
            end
            an_reg  <= ~(DIGITS'(1) << scan_idx_reg);
            seg_reg <= cur_blank ? 7'h7F : decode(cur_digit);
        end
    end

    assign bus.an       = an_reg;
    assign bus.seg      = seg_reg;
    assign bus.dp       = 1'b1;
    assign bus.busy     = (state_reg != IDLE);
    assign bus.overflow = overflow_reg;
endmodule

// File: tb/tb_blink_count_display.sv
module tb_blink_count_display;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   rises  = 0;
    logic busy_prev = 1'b0;
    logic mon_en = 1'b0;

    blink_count_display_if #(.DIGITS(4)) bus ();

    blink_count_display #(
        .DIGITS(4), .REFRESH_DIV(4), .LZ_BLANK(1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Counts rising edges of busy while enabled.
    always @(negedge clk) begin
        if (mon_en && bus.busy && !busy_prev) rises++;
        busy_prev = bus.busy;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
        $display("check %s observed=%0h expected=%0h", tag, obs, exp_v);
    endtask

    // Wait (bounded) for the given anode slot and compare its segment pattern.
    task automatic chk_digit(input string tag, input logic [3:0] an_want, input logic [6:0] seg_exp);
        logic       found;
        logic [6:0] s;
        found = 1'b0;
        s = 7'h00;
        for (int i = 0; i < 16 && !found; i++) begin
            @(negedge clk);
            if (bus.an === an_want) begin
                found = 1'b1;
                s = bus.seg;
            end
        end
        checks++;
        assert (found && s === seg_exp) else begin
            errors++;
            $error("FAIL %s an=%b found=%0d observed=%b expected=%b", tag, an_want, found, s, seg_exp);
        end
        $display("check %s an=%b seg=%b expected=%b", tag, an_want, s, seg_exp);
    endtask

    task automatic wait_idle(input string tag);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (!bus.busy) done = 1'b1;
        end
        chk({tag, "_idle"}, {31'd0, done}, 32'd1);
    endtask

    task automatic convert(input string tag, input logic [31:0] v);
        bus.count_in = v;
        @(negedge clk);
        chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
        wait_idle(tag);
    endtask

    initial begin
        // Reset held with a nonzero input.
        bus.count_in = 32'd7;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_an", {28'd0, bus.an}, 32'hF);
        chk("rst_seg", {25'd0, bus.seg}, 32'h7F);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_ovf", {31'd0, bus.overflow}, 32'd0);
        chk("rst_dp", {31'd0, bus.dp}, 32'd1);

        rst = 1'b1;
        @(negedge clk);
        chk("rel_busy", {31'd0, bus.busy}, 32'd1);
        chk("rel_an", {28'd0, bus.an}, 32'hE);
        // Latch edge was the first one; 32 shifts and a commit follow.
        repeat (31) @(negedge clk);
        chk("conv_busy_mid", {31'd0, bus.busy}, 32'd1);
        wait_idle("first");
        chk_digit("d7_0", 4'b1110, 7'b1111000);
        chk_digit("d7_1", 4'b1101, 7'h7F);

        convert("c1234", 32'd1234);
        chk_digit("1234_0", 4'b1110, 7'b0011001);
        chk_digit("1234_3", 4'b0111, 7'b1111001);
        chk_digit("1234_1", 4'b1101, 7'b0110000);
        chk("1234_ovf", {31'd0, bus.overflow}, 32'd0);

        convert("c12345", 32'd12345);
        chk("12345_ovf", {31'd0, bus.overflow}, 32'd1);
        chk_digit("12345_3", 4'b0111, 7'b0100100);
        chk_digit("12345_0", 4'b1110, 7'b0010010);

        convert("cmax", 32'hFFFF_FFFF);
        chk("max_ovf", {31'd0, bus.overflow}, 32'd1);
        chk_digit("max_3", 4'b0111, 7'b1111000);
        chk_digit("max_2", 4'b1011, 7'b0100100);
        chk_digit("max_1", 4'b1101, 7'b0010000);
        chk_digit("max_0", 4'b1110, 7'b0010010);

        convert("c5", 32'd5);
        chk("5_ovf", {31'd0, bus.overflow}, 32'd0);
        chk_digit("5_3", 4'b0111, 7'h7F);
        chk_digit("5_2", 4'b1011, 7'h7F);
        chk_digit("5_1", 4'b1101, 7'h7F);
        chk_digit("5_0", 4'b1110, 7'b0010010);

        convert("c0", 32'd0);
        chk_digit("0_0", 4'b1110, 7'b1000000);
        chk_digit("0_1", 4'b1101, 7'h7F);

        // Back-to-back changes 1 -> 2 -> 3.
        rises = 0;
        mon_en = 1'b1;
        bus.count_in = 32'd1;
        @(negedge clk);
        bus.count_in = 32'd2;
        @(negedge clk);
        bus.count_in = 32'd3;
        wait_idle("b2b_first");
        chk_digit("b2b_1", 4'b1110, 7'b1111001);
        wait_idle("b2b_second");
        chk_digit("b2b_3", 4'b1110, 7'b0110000);
        repeat (40) @(negedge clk);
        chk("b2b_rises", rises, 32'd2);
        chk("b2b_idle", {31'd0, bus.busy}, 32'd0);
        mon_en = 1'b0;

        // Reset in the middle of a conversion.
        bus.count_in = 32'd42;
        @(negedge clk);
        chk("abort_busy", {31'd0, bus.busy}, 32'd1);
        repeat (10) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy0", {31'd0, bus.busy}, 32'd0);
        chk("abort_an", {28'd0, bus.an}, 32'hF);
        chk("abort_seg", {25'd0, bus.seg}, 32'h7F);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_rel_busy", {31'd0, bus.busy}, 32'd1);
        chk_digit("abort_d0", 4'b1110, 7'b1000000);
        wait_idle("abort_conv");
        chk_digit("42_0", 4'b1110, 7'b0100100);
        chk_digit("42_1", 4'b1101, 7'b0011001);
        chk_digit("42_2", 4'b1011, 7'h7F);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global guard so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout guard expired");
        $fatal(1, "timeout");
    end
endmodule
